// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display register block and its BCD engine.
package display_pkg;

  // Register word offsets on the data-memory bus.
  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RAW    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL field positions.
  localparam int unsigned CTRL_EN_LSB   = 0;
  localparam int unsigned CTRL_DOTS_LSB = 4;
  localparam int unsigned CTRL_RAW_MODE = 8;
  localparam int unsigned CTRL_LZ_BLANK = 9;
  localparam int unsigned CTRL_W        = 10;

  // All digits enabled, no dots, BCD mode, no blanking.
  localparam logic [CTRL_W-1:0] CTRL_RESET = 10'h00F;

  // STATUS bit positions.
  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_OVF  = 1;

  // Conversion constants.
  localparam int unsigned VALUE_MAX  = 9999;
  localparam int unsigned BCD_ITER   = 14;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned ITER_CNT_W = $clog2(BCD_ITER);

  typedef enum logic {
    StIdle,
    StShift
  } bcd_state_e;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 after the shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned VALUE_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  localparam int unsigned SR_W = BCD_W + VALUE_W;

  bcd_state_e              state_q;
  logic [SR_W-1:0]         shift_q;
  logic [ITER_CNT_W-1:0]   cnt_q;
  logic [SR_W-1:0]         adj;
  logic [SR_W-1:0]         shifted;
  logic                    last_iter;

  // Add-3 correction on every BCD nibble (no inter-nibble carry), then shift left by one.
  always_comb begin
    adj = shift_q;
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      adj[VALUE_W + 4*i +: 4] = dabble_adj(shift_q[VALUE_W + 4*i +: 4]);
    end
    shifted   = {adj[SR_W-2:0], 1'b0};
    last_iter = (cnt_q == ITER_CNT_W'(BCD_ITER - 1));
  end

  // A start on the final edge aborts the completion, so done is masked by start.
  assign busy = (state_q == StShift);
  assign done = busy && last_iter && !start;
  assign bcd  = shifted[SR_W-1 -: BCD_W];

  // Conversion FSM: start (re)loads from any state, SHIFT runs BCD_ITER iterations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      state_q <= StShift;
      shift_q <= {{BCD_W{1'b0}}, value};
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StIdle;
        end
        StShift: begin
          shift_q <= shifted;
          if (last_iter) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/display_bcd_regs.sv
// Memory-mapped register block driving the 4-digit 7-segment display controller.
module display_bcd_regs
  import display_pkg::*;
#(
  parameter int unsigned VALUE_W  = 14,
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                we,
  input  logic [1:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [3:0]          num0,
  output logic [3:0]          num1,
  output logic [3:0]          num2,
  output logic [3:0]          num3,
  output logic [N_DIGITS-1:0] nums_enable,
  output logic [N_DIGITS-1:0] dots_enable,
  output logic                busy
);

  logic [VALUE_W-1:0]  value_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [BCD_W-1:0]    raw_q;
  logic                ovf_q;
  logic [BCD_W-1:0]    digits_q;

  logic                wr_value;
  logic                wr_ctrl;
  logic                wr_raw;
  logic [VALUE_W-1:0]  wr_val;
  logic                wr_over;
  logic [VALUE_W-1:0]  load_val;

  logic                conv_done;
  logic [BCD_W-1:0]    conv_bcd;

  logic [N_DIGITS-1:0] ctrl_en;
  logic [N_DIGITS-1:0] ctrl_dots;
  logic                raw_mode;
  logic                lz_blank;
  logic [N_DIGITS-1:0] blank_mask;
  logic [BCD_W-1:0]    num_sel;
  logic                zero_run;

  // Upper write-data bits are not mapped to any register.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  assign wr_value = sel && we && (addr == ADDR_VALUE);
  assign wr_ctrl  = sel && we && (addr == ADDR_CTRL);
  assign wr_raw   = sel && we && (addr == ADDR_RAW);

  // Clamp oversize values so the 4-digit BCD result cannot overflow.
  assign wr_val   = wdata[VALUE_W-1:0];
  assign wr_over  = (wr_val > VALUE_W'(VALUE_MAX));
  assign load_val = wr_over ? VALUE_W'(VALUE_MAX) : wr_val;

  assign ctrl_en   = ctrl_q[CTRL_EN_LSB +: N_DIGITS];
  assign ctrl_dots = ctrl_q[CTRL_DOTS_LSB +: N_DIGITS];
  assign raw_mode  = ctrl_q[CTRL_RAW_MODE];
  assign lz_blank  = ctrl_q[CTRL_LZ_BLANK];

  bin_to_bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (wr_value),
    .value (load_val),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Register file; VALUE keeps the unclamped write, ovf tracks the latest VALUE write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      ctrl_q  <= CTRL_RESET;
      raw_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_value) begin
        value_q <= wr_val;
        ovf_q   <= wr_over;
      end
      if (wr_ctrl) begin
        ctrl_q <= wdata[CTRL_W-1:0];
      end
      if (wr_raw) begin
        raw_q <= wdata[BCD_W-1:0];
      end
    end
  end

  // Displayed digits only change on a completed, non-aborted conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
    end else if (conv_done) begin
      digits_q <= conv_bcd;
    end
  end

  // Combinational read mux; unmapped bits read as zero.
  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_VALUE:  rdata[VALUE_W-1:0] = value_q;
      ADDR_CTRL:   rdata[CTRL_W-1:0]  = ctrl_q;
      ADDR_RAW:    rdata[BCD_W-1:0]   = raw_q;
      ADDR_STATUS: begin
        rdata[STATUS_BUSY] = busy;
        rdata[STATUS_OVF]  = ovf_q;
      end
      default:     rdata = '0;
    endcase
  end

  // Leading-zero blanking: a digit blanks when it and every higher digit is zero; digit 0 never.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    if (!raw_mode && lz_blank) begin
      for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
        zero_run      = zero_run && (digits_q[4*i +: 4] == 4'd0);
        blank_mask[i] = zero_run;
      end
    end
  end

  // Output mux toward the display controller.
  always_comb begin
    num_sel     = raw_mode ? raw_q : digits_q;
    num0        = num_sel[3:0];
    num1        = num_sel[7:4];
    num2        = num_sel[11:8];
    num3        = num_sel[15:12];
    nums_enable = ctrl_en & ~blank_mask;
    dots_enable = ctrl_dots;
  end

endmodule

// File: tb/tb_display_bcd_regs.sv
// Directed self-checking bench for display_bcd_regs.
module tb_display_bcd_regs;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  num0, num1, num2, num3;
  logic [3:0]  nums_enable;
  logic [3:0]  dots_enable;
  logic        busy;
  logic [15:0] nums;

  int n_checks = 0;
  int n_errors = 0;

  display_bcd_regs #(
    .VALUE_W  (14),
    .N_DIGITS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .num0        (num0),
    .num1        (num1),
    .num2        (num2),
    .num3        (num3),
    .nums_enable (nums_enable),
    .dots_enable (dots_enable),
    .busy        (busy)
  );

  assign nums = {num3, num2, num1, num0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
    @(negedge clk);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    rst   = 1'b1;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_nums", {16'h0, nums}, 32'h0);
    check("rst_en", {28'h0, nums_enable}, 32'hF);
    check("rst_dots", {28'h0, dots_enable}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    read_check("rst_ctrl", 2'd1, 32'h00F);
    read_check("rst_status", 2'd3, 32'h0);

    // VALUE=1234: busy through E1..E13, digits stay 0, commit at E14
    bus_write(2'd0, 32'd1234);
    check("v1234_busy_e0", {31'h0, busy}, 32'h1);
    for (int k = 1; k <= 13; k++) begin
      wait_edges(1);
      check($sformatf("v1234_busy_e%0d", k), {31'h0, busy}, 32'h1);
      check($sformatf("v1234_hold_e%0d", k), {16'h0, nums}, 32'h0);
    end
    wait_edges(1);
    check("v1234_nums", {16'h0, nums}, 32'h1234);
    check("v1234_busy_e14", {31'h0, busy}, 32'h0);
    read_check("v1234_value", 2'd0, 32'd1234);

    // Overflow clamp, then clearing ovf
    bus_write(2'd0, 32'd12000);
    wait_edges(14);
    check("v12000_nums", {16'h0, nums}, 32'h9999);
    read_check("v12000_status", 2'd3, 32'h2);
    read_check("v12000_value", 2'd0, 32'd12000);
    bus_write(2'd0, 32'd5);
    read_check("v5_status_busy", 2'd3, 32'h1);
    wait_edges(14);
    check("v5_nums", {16'h0, nums}, 32'h0005);
    read_check("v5_status", 2'd3, 32'h0);

    // STATUS is read-only
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_check("status_ro", 2'd3, 32'h0);
    check("status_ro_busy", {31'h0, busy}, 32'h0);

    // Leading-zero blanking
    bus_write(2'd1, 32'h20F);
    bus_write(2'd0, 32'd7);
    wait_edges(14);
    check("lz7_nums", {16'h0, nums}, 32'h0007);
    check("lz7_en", {28'h0, nums_enable}, 32'b0001);
    bus_write(2'd0, 32'd1005);
    wait_edges(14);
    check("lz1005_nums", {16'h0, nums}, 32'h1005);
    check("lz1005_en", {28'h0, nums_enable}, 32'b1111);
    bus_write(2'd0, 32'd50);
    wait_edges(14);
    check("lz50_en", {28'h0, nums_enable}, 32'b0011);
    bus_write(2'd0, 32'd0);
    wait_edges(14);
    check("lz0_nums", {16'h0, nums}, 32'h0000);
    check("lz0_en", {28'h0, nums_enable}, 32'b0001);

    // Raw mode with dots, visible right after the write edge
    bus_write(2'd1, 32'h1FF);
    bus_write(2'd2, 32'hBEEF);
    check("raw_nums", {16'h0, nums}, 32'hBEEF);
    check("raw_dots", {28'h0, dots_enable}, 32'hF);
    check("raw_en", {28'h0, nums_enable}, 32'hF);
    read_check("raw_rd", 2'd2, 32'hBEEF);
    read_check("ctrl_rd", 2'd1, 32'h1FF);

    // Abort: 1111 restarted by 42 at E5; 1111 must never appear
    bus_write(2'd1, 32'h00F);
    bus_write(2'd0, 32'd1111);
    wait_edges(4);
    bus_write(2'd0, 32'd42);
    for (int k = 1; k <= 13; k++) begin
      wait_edges(1);
      check($sformatf("abort_hold_e%0d", k), {16'h0, nums}, 32'h0000);
    end
    wait_edges(1);
    check("abort_nums", {16'h0, nums}, 32'h0042);
    check("abort_busy", {31'h0, busy}, 32'h0);

    // Async reset mid-conversion at E7
    bus_write(2'd1, 32'h0A3);
    check("pre_rst_dots", {28'h0, dots_enable}, 32'hA);
    bus_write(2'd0, 32'd9876);
    wait_edges(6);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_nums", {16'h0, nums}, 32'h0);
    check("mid_rst_en", {28'h0, nums_enable}, 32'hF);
    check("mid_rst_dots", {28'h0, dots_enable}, 32'h0);
    read_check("mid_rst_ctrl", 2'd1, 32'h00F);
    read_check("mid_rst_value", 2'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_edges(14);
    check("post_rst_nums", {16'h0, nums}, 32'h0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_bcd_regs.md
Name: display_bcd_regs

Overview:
Memory-mapped peripheral register block that feeds the 4-digit 7-segment display controller. It sits on the data-memory bus of the single-cycle core. The CPU writes either a binary value or raw hex nibbles. A sequential double-dabble engine converts binary values to BCD. The block drives the controller's num0..num3, nums_enable and dots_enable inputs.

Parameters:
VALUE_W, 14, width of the binary value register (holds 0..9999)
N_DIGITS, 4, number of display digits (fixed at 4; not generic beyond that)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sel  input  1  peripheral selected by the bus address decoder
we  input  1  write strobe; a write takes effect at the clk edge when sel&we
addr  input  2  word offset: 0=VALUE, 1=CTRL, 2=RAW, 3=STATUS
wdata  input  32  write data
rdata  output  32  combinational read data for addr (independent of sel)
num0..num3  output  4 each  digit nibbles to the display controller (num0 = rightmost)
nums_enable  output  4  per-digit enable to the display controller
dots_enable  output  4  per-digit decimal point to the display controller
busy  output  1  conversion in progress (mirrors STATUS[0])

Behaviour:
- Registers:
  - VALUE[13:0] is R/W and holds the last written value, not the clamped one.
  - CTRL bits: [3:0] en, [7:4] dots, [8] raw_mode, [9] lz_blank; R/W.
  - RAW[15:0] holds 4 hex nibbles, digit3 in the MSB; R/W.
  - STATUS bits: [0] busy, [1] ovf; read-only, and writes to it are ignored.
  - Unused bits read 0.
- Reset (async, any time, including mid-conversion):
  - VALUE=0, CTRL=0x00F, RAW=0, busy=0, ovf=0, BCD digit registers=0.
  - Resulting outputs: num*=0, nums_enable=4'hF, dots_enable=0.
- VALUE write at edge E0:
  - wdata[13:0] > 9999 → the engine is loaded with 9999 and ovf is set at E0. Otherwise ovf clears at E0.
  - At E0: the shift register is loaded, the iteration counter is set to 0, busy=1.
- Conversion FSM states: IDLE → SHIFT → IDLE.
  - SHIFT: each edge adds 3 to every BCD nibble ≥5, then shifts the whole register left by 1.
  - There are exactly 14 iterations, at edges E1..E14.
  - At E14 the BCD digit registers update atomically and busy clears. Digits change exactly 14 cycles after the write edge.
  - Previous digits stay displayed throughout the conversion; intermediate values never appear on the outputs.
- VALUE write while busy: the current conversion is aborted and restarts from the new value, with the same E0 semantics. The old partial result is never committed.
- CTRL and RAW writes take effect at the write edge. Outputs follow in the same cycle, since the output path is combinational from registers. Writing them does not disturb the conversion.
- Output mux:
  - raw_mode=1 → num_i = RAW[4i+3:4i].
  - raw_mode=0 → num_i = BCD digit i.
  - dots_enable = CTRL.dots.
- Leading-zero blanking applies only when raw_mode=0 and lz_blank=1:
  - Digit i (i=3..1) is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - nums_enable = CTRL.en & ~blank_mask. Otherwise nums_enable = CTRL.en.
- Width rules: add-3 is applied per 4-bit nibble (no carry between nibbles). The BCD field is 16 bits. Inputs above 9999 are clamped before loading, so the BCD result never overflows.
- Simultaneous write and completion: a VALUE write at E14 wins. The completion is discarded and a restart happens.

Decomposition:
- Shared package `display_pkg`:
  - register offsets ADDR_VALUE/CTRL/RAW/STATUS
  - CTRL bit positions
  - VALUE_MAX=9999
  - BCD_ITER=14
- One sub-module `bin_to_bcd_seq` (double-dabble engine):
  - Inputs: start, value[13:0].
  - Outputs: busy, done pulse, bcd[15:0].
  - Implements the IDLE/SHIFT FSM and the iteration counter.
- `display_bcd_regs` holds:
  - the register file
  - clamp/ovf logic
  - the output mux
  - blanking logic

Test Plan:
- Reset with no writes → num=0,0,0,0; nums_enable=4'hF; dots=0; rdata@CTRL=0x00F.
- Write VALUE=1234 → busy=1 for 14 cycles; at E14 num3..num0 = 1,2,3,4 and busy=0; num stays 0 during E1..E13.
- Write VALUE=12000 → after 14 cycles digits are 9,9,9,9 and STATUS=0x2. Then write 5 → ovf=0 and digits 0,0,0,5.
- CTRL=0x20F (lz_blank), VALUE=7 → nums_enable=4'b0001. VALUE=1005 → nums_enable=4'b1111. VALUE=0 → 4'b0001.
- CTRL=0x1FF, RAW=0xBEEF → same cycle num3..num0 = B,E,E,F; dots_enable=4'hF.
- Write VALUE=1111, then at E5 write 42 → final digits 0,0,4,2 at 14 cycles after the second write, with 1111 never shown. Assert rst at E7 of a new conversion → busy=0 and all outputs return to reset values immediately.
